// File: rtl/pong_kbd_pkg.sv
// pong_kbd_pkg: shared types and helpers for the Pong keypad scanner.
//   scan_state_t  : scanner FSM states
//   KEY_NONE      : 5-bit scan result meaning "no key" (MSB set)
//   lowest_key()  : lowest set bit index of a 16-bit scan map, or KEY_NONE
package pong_kbd_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_DRIVE  = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_EVAL   = 2'd2
    } scan_state_t;

    localparam logic [4:0] KEY_NONE = 5'b1_0000;

    function automatic logic [4:0] lowest_key(input logic [15:0] map);
        logic [4:0] k;
        k = KEY_NONE;
        // Walk downwards so the last hit written is the lowest index.
        for (int i = 15; i >= 0; i--) begin
            if (map[i]) k = {1'b0, i[3:0]};
        end
        return k;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a scan result only after DEBOUNCE_SCANS identical
// consecutive scans, then updates the held key outputs.
// Optional feature macro: KEYPAD_STROBE_EN (adds o_key_strobe).
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_eval           one-cycle strobe, i_result valid
//   i_result [4:0]   scan result (KEY_NONE when no key)
//   o_key [3:0]      last accepted key index
//   o_keypressed     high while an accepted key is held
//   o_key_strobe     (KEYPAD_STROBE_EN) one-cycle pulse on a new accepted press
module keypad_debounce
    import pong_kbd_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_eval,
    input  logic [4:0] i_result,
    output logic [3:0] o_key,
`ifdef KEYPAD_STROBE_EN
    output logic       o_key_strobe,
`endif
    output logic       o_keypressed
);

    localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

    logic [4:0] r_cand;
    logic [3:0] r_cnt;
    logic [3:0] r_key;
    logic       r_kp;
    logic [3:0] w_cnt_nxt;
    logic       w_accept;

    always_comb begin
        w_cnt_nxt = 4'd1;
        if (i_result == r_cand) begin
            w_cnt_nxt = (r_cnt >= DS) ? DS : r_cnt + 4'd1;
        end
        w_accept = i_eval && (w_cnt_nxt == DS);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cand <= KEY_NONE;
            r_cnt  <= 4'd0;
            r_key  <= 4'd0;
            r_kp   <= 1'b0;
        end else if (i_eval) begin
            r_cand <= i_result;
            r_cnt  <= w_cnt_nxt;
            if (w_accept) begin
                if (!i_result[4]) begin
                    r_key <= i_result[3:0];
                    r_kp  <= 1'b1;
                end else begin
                    r_kp  <= 1'b0;
                end
            end
        end
    end

`ifdef KEYPAD_STROBE_EN
    logic r_strobe;

    // A re-accept of the key already held is not a new press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_accept && !i_result[4] &&
                        (!r_kp || (r_key != i_result[3:0]));
        end
    end

    assign o_key_strobe = r_strobe;
`endif

    assign o_key        = r_key;
    assign o_keypressed = r_kp;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces it and
// presents the accepted key index and a held flag.
// Optional feature macro: KEYPAD_STROBE_EN (adds o_key_strobe).
// Ports:
//   i_clk          system clock
//   i_rst_n        async active-low reset
//   i_row [3:0]    keypad rows, active-low, asynchronous
//   o_col [3:0]    column drive, active-low, one-cold
//   o_key [3:0]    accepted key index (row*4 + col)
//   o_keypressed   high while an accepted key is held
//   o_key_strobe   (KEYPAD_STROBE_EN) one-cycle pulse on a new accepted press
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_DRIVE  | column driven, dwell counter running 0..DWELL-2
// ST_SAMPLE | dwell counter at DWELL-1, rows captured, column advances
// ST_EVAL   | full map complete, result to debouncer, map cleared
module keypad_scanner
    import pong_kbd_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int COL_HZ         = 4_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic [3:0] o_key,
`ifdef KEYPAD_STROBE_EN
    output logic       o_key_strobe,
`endif
    output logic       o_keypressed
);

    localparam int DWELL_RAW = CLK_HZ / COL_HZ;
    localparam int DWELL     = (DWELL_RAW < 4) ? 4 : DWELL_RAW;
    localparam int CW        = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_PRE = CW'(DWELL - 2);

    logic [3:0]  r_row_meta;
    logic [3:0]  r_row_sync;
    scan_state_t r_state;
    scan_state_t w_next;
    logic [CW-1:0] r_cnt;
    logic [1:0]  r_col;
    logic [15:0] r_map;
    logic [15:0] w_col_hits;
    logic [4:0]  w_result;
    logic        w_eval;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= i_row;
            r_row_sync <= r_row_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_DRIVE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_eval = 1'b0;
        case (r_state)
            ST_DRIVE:  if (r_cnt == CNT_PRE) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = (r_col == 2'd3) ? ST_EVAL : ST_DRIVE;
            ST_EVAL: begin
                w_eval = 1'b1;
                w_next = ST_DRIVE;
            end
            default:   w_next = ST_DRIVE;
        endcase
    end

    // Hits for the currently driven column, placed at bit row*4+col.
    always_comb begin
        w_col_hits = 16'd0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            w_col_hits[{r[1:0], r_col}] = ~r_row_sync[r];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_col <= 2'd0;
            r_map <= 16'd0;
        end else begin
            case (r_state)
                ST_DRIVE: r_cnt <= r_cnt + 1'b1;
                ST_SAMPLE: begin
                    r_cnt <= '0;
                    r_col <= r_col + 2'd1;
                    r_map <= r_map | w_col_hits;
                end
                ST_EVAL:  r_map <= 16'd0;
                default: begin
                    r_cnt <= '0;
                    r_col <= 2'd0;
                    r_map <= 16'd0;
                end
            endcase
        end
    end

    assign o_col    = ~(4'b0001 << r_col);
    assign w_result = lowest_key(r_map);

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_eval       (w_eval),
        .i_result     (w_result),
        .o_key        (o_key),
`ifdef KEYPAD_STROBE_EN
        .o_key_strobe (o_key_strobe),
`endif
        .o_keypressed (o_keypressed)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a keypad row model.
// Timing reference: posedge index p counted from reset release; EVAL edge of
// scan k is p = 40 + 41*(k-1). Outputs are sampled on the following negedge.
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  i_row;
    logic [3:0]  o_col;
    logic [3:0]  o_key;
    logic        o_keypressed;
`ifdef KEYPAD_STROBE_EN
    logic        o_key_strobe;
    int          n_strobe;
`endif
    logic [15:0] keys;
    int          n_pos;
    int          n_cmp;
    int          n_bad;
    int          snap;

    keypad_scanner #(
        .CLK_HZ         (1000),
        .COL_HZ         (100),
        .DEBOUNCE_SCANS (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_row        (i_row),
        .o_col        (o_col),
        .o_key        (o_key),
`ifdef KEYPAD_STROBE_EN
        .o_key_strobe (o_key_strobe),
`endif
        .o_keypressed (o_keypressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row r is pulled low when a pressed key in row r sits on the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            i_row[r] = ~|(keys[r*4 +: 4] & ~o_col);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_pos <= 0;
        else        n_pos <= n_pos + 1;
    end

`ifdef KEYPAD_STROBE_EN
    initial n_strobe = 0;
    always @(negedge clk) if (o_key_strobe === 1'b1) n_strobe = n_strobe + 1;
`endif

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_pos(input int p);
        int guard;
        guard = 0;
        while (n_pos < p + 1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) chk("wait_timeout", 16'(n_pos), 16'(p + 1));
    endtask

    task automatic at_eval(input int k);
        wait_pos(40 + 41 * (k - 1));
    endtask

    task automatic chk_out(input string tag, input logic kp, input logic [3:0] key);
        chk({tag, "_kp"}, {15'd0, o_keypressed}, {15'd0, kp});
        chk({tag, "_key"}, {12'd0, o_key}, {12'd0, key});
    endtask

    function automatic logic [15:0] kbit(input int k);
        logic [15:0] m;
        m = 16'd0;
        m[k] = 1'b1;
        return m;
    endfunction

    int          walk_p   [7] = '{0, 8, 9, 18, 19, 29, 39};
    logic [3:0]  walk_col [7] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        keys  = 16'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_col", {12'd0, o_col}, 16'h000E);
        chk_out("rst", 1'b0, 4'd0);
`ifdef KEYPAD_STROBE_EN
        chk("rst_strobe", {15'd0, o_key_strobe}, 16'd0);
`endif
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            wait_pos(walk_p[i]);
            chk($sformatf("walk_col_p%0d", walk_p[i]), {12'd0, o_col}, {12'd0, walk_col[i]});
            chk($sformatf("walk_onehot_p%0d", walk_p[i]), 16'($countones(~o_col)), 16'd1);
        end

        // Clean press of key 6 for scans 2..5.
        at_eval(1);
        keys = kbit(6);
        at_eval(4);
        chk_out("k6_e4", 1'b0, 4'd0);
        wait_pos(40 + 41 * 4 - 1);
        chk_out("k6_pre", 1'b0, 4'd0);
`ifdef KEYPAD_STROBE_EN
        snap = n_strobe;
`endif
        at_eval(5);
        chk_out("k6_acc", 1'b1, 4'd6);
`ifdef KEYPAD_STROBE_EN
        chk("k6_strobe", {15'd0, o_key_strobe}, 16'd1);
`endif
        keys = 16'd0;
        at_eval(8);
        chk_out("k6_rel_e8", 1'b1, 4'd6);
        at_eval(9);
        chk_out("k6_rel_e9", 1'b0, 4'd6);
`ifdef KEYPAD_STROBE_EN
        chk("k6_strobe_cnt", 16'(n_strobe - snap), 16'd1);
`endif

        // Key 9 bounces for three scans, then stays pressed.
        keys = kbit(9);
        at_eval(10); chk_out("b9_e10", 1'b0, 4'd6); keys = 16'd0;
        at_eval(11); chk_out("b9_e11", 1'b0, 4'd6); keys = kbit(9);
        for (int k = 12; k <= 14; k++) begin
            at_eval(k);
            chk_out($sformatf("b9_e%0d", k), 1'b0, 4'd6);
        end
        at_eval(15);
        chk_out("b9_acc", 1'b1, 4'd9);

        // Keys 3 and 12 together, then 3 released.
        keys = kbit(3) | kbit(12);
        for (int k = 16; k <= 18; k++) begin
            at_eval(k);
            chk_out($sformatf("two_e%0d", k), 1'b1, 4'd9);
        end
        at_eval(19);
        chk_out("two_acc3", 1'b1, 4'd3);
        keys = kbit(12);
        for (int k = 20; k <= 22; k++) begin
            at_eval(k);
            chk_out($sformatf("k12_e%0d", k), 1'b1, 4'd3);
        end
        at_eval(23);
        chk_out("k12_acc", 1'b1, 4'd12);

        // Asynchronous reset in the middle of a column while key 12 is held.
        wait_pos(40 + 41 * 22 + 5);
        #2 rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 4'd0);
        chk("arst_col", {12'd0, o_col}, 16'h000E);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        at_eval(3);
        chk_out("reacq_e3", 1'b0, 4'd0);
        at_eval(4);
        chk_out("reacq_e4", 1'b1, 4'd12);

        // Release, then a fresh press of key 5.
        keys = 16'd0;
        at_eval(8);
        chk_out("rel12", 1'b0, 4'd12);
        keys = kbit(5);
`ifdef KEYPAD_STROBE_EN
        snap = n_strobe;
`endif
        at_eval(11);
        chk_out("k5_e11", 1'b0, 4'd12);
        at_eval(12);
        chk_out("k5_acc", 1'b1, 4'd5);
`ifdef KEYPAD_STROBE_EN
        chk("k5_strobe", {15'd0, o_key_strobe}, 16'd1);
`endif
        keys = 16'd0;
        at_eval(13);
`ifdef KEYPAD_STROBE_EN
        chk("k5_strobe_cnt", 16'(n_strobe - snap), 16'd1);
        snap = n_strobe;
`endif
        at_eval(17);
        chk_out("k5_rel", 1'b0, 4'd5);
`ifdef KEYPAD_STROBE_EN
        chk("k5_rel_strobe_cnt", 16'(n_strobe - snap), 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
